// File: rtl/alu_seq_param.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/add/sub/neg ops, iterative shift-add MUL
// and restoring DIV, with a result register held until the consumer takes it.
module alu_seq_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] opb;      // multiplier (shifted right) in MUL, divisor in DIV
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc_next;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    logic             wr_en;
    logic [WIDTH-1:0] wr_res;
    logic             wr_carry;
    logic             wr_dbz;

    assign in_ready = (state == S_IDLE) && !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CW'(WIDTH - 1));

    // Adder plus one iteration step of the multiplier and of the divider
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        acc_next = acc + (opb[0] ? mcand : '0);
        shifted  = {rem, quo[WIDTH-1]};
        ge       = (shifted >= {1'b0, opb});
        rem_next = ge ? (shifted[WIDTH-1:0] - opb) : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
    end

    // Result write request: single-cycle ops at accept, iterative ops on their last step
    always_comb begin
        wr_en    = 1'b0;
        wr_res   = '0;
        wr_carry = 1'b0;
        wr_dbz   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    case (sel)
                        OP_NOT: wr_res = ~a;
                        OP_OR:  wr_res = a | b;
                        OP_AND: wr_res = a & b;
                        OP_NEG: wr_res = ~a + WIDTH'(1);
                        OP_ADD: begin
                            wr_res   = sum[WIDTH-1:0];
                            wr_carry = sum[WIDTH];
                        end
                        OP_SUB: begin
                            wr_res   = a - b;
                            wr_carry = (a < b);
                        end
                        OP_MUL: wr_en = 1'b0;
                        OP_DIV: begin
                            if (b == '0) begin
                                wr_res = '1;
                                wr_dbz = 1'b1;
                            end else begin
                                wr_en = 1'b0;
                            end
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (last) begin
                    wr_en    = 1'b1;
                    wr_res   = acc_next[WIDTH-1:0];
                    wr_carry = |acc_next[PW-1:WIDTH];
                end
            end
            S_DIV: begin
                if (last) begin
                    wr_en  = 1'b1;
                    wr_res = quo_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            opb         <= '0;
            rem         <= '0;
            quo         <= '0;
            out_valid   <= 1'b0;
            out         <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A write in the same cycle as a consume keeps out_valid set
            if (wr_en) begin
                out_valid   <= 1'b1;
                out         <= wr_res;
                zero        <= (wr_res == '0);
                carry       <= wr_carry;
                div_by_zero <= wr_dbz;
            end
            case (state)
                S_IDLE: begin
                    if (accept && sel == OP_MUL) begin
                        state <= S_MUL;
                        cnt   <= '0;
                        acc   <= '0;
                        mcand <= PW'(a);
                        opb   <= b;
                    end else if (accept && sel == OP_DIV && b != '0) begin
                        state <= S_DIV;
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= a;
                        opb   <= b;
                    end
                end
                S_MUL: begin
                    acc   <= acc_next;
                    mcand <= {mcand[PW-2:0], 1'b0};
                    opb   <= {1'b0, opb[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param: a 32-bit and an 8-bit instance, results checked
// against an independent 64-bit reference model.
module tb_alu_seq_param;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        carry;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero, carry, div_by_zero;
    logic [31:0] a, b, out;
    logic [2:0]  sel;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, carry8, dbz8;
    logic [7:0]  a8, b8, out8;
    logic [2:0]  sel8;

    int   checks = 0;
    int   errors = 0;
    exp_t q32[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .carry(carry), .div_by_zero(div_by_zero)
    );

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .zero(zero8), .carry(carry8), .div_by_zero(dbz8)
    );

    function automatic exp_t model(input logic [2:0] s, input logic [31:0] x,
                                   input logic [31:0] y, input int w);
        logic [63:0] m, xa, yb, r;
        exp_t e;
        m  = (64'd1 << w) - 64'd1;
        xa = {32'd0, x} & m;
        yb = {32'd0, y} & m;
        e  = '0;
        r  = '0;
        case (s)
            3'd0: r = ~xa;
            3'd1: r = xa | yb;
            3'd2: r = xa & yb;
            3'd3: r = 64'd0 - xa;
            3'd4: begin r = xa + yb; e.carry = r[w]; end
            3'd5: begin r = xa - yb; e.carry = (xa < yb); end
            3'd6: begin r = xa * yb; e.carry = ((r >> w) != 64'd0); end
            default: begin
                if (yb == 64'd0) begin r = m; e.dbz = 1'b1; end
                else r = xa / yb;
            end
        endcase
        r      = r & m;
        e.res  = r[31:0];
        e.zero = (r == 64'd0);
        return e;
    endfunction

    task automatic issue32(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y,
                           input bit push, output int waited);
        in_valid = 1'b1; sel = s; a = x; b = y; waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_accept: in_ready=%b required 1 within 100 cycles", in_ready);
        end else if (push) begin
            q32.push_back(model(s, x, y, 32));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; sel = 3'($urandom);
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out, zero, carry, div_by_zero, in_ready} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b out=%h z=%b c=%b dbz=%b rdy=%b required all 0",
                     out_valid, out, zero, carry, div_by_zero, in_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b in_ready8=%b out_valid8=%b required 1 1 0",
                     in_ready, in_ready8, out_valid8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ops_back_to_back();
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin in_valid = 1'b1; sel = 3'(i); a = 32'd3; b = 32'd5; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || q32.size() == 0) begin
                    errors++;
                    $display("FAIL ops_latency: op %0d out_valid=%b required 1", i - 1, out_valid);
                end else begin
                    e = q32.pop_front();
                    checks++;
                    if ({out, zero, carry, div_by_zero} !== {e.res, e.zero, e.carry, e.dbz}) begin
                        errors++;
                        $display("FAIL ops_result: op %0d out=%h z=%b c=%b dbz=%b required %h %b %b %b",
                                 i - 1, out, zero, carry, div_by_zero, e.res, e.zero, e.carry, e.dbz);
                    end
                end
            end
            if (i < 6) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ops_ready: op %0d in_ready=%b required 1", i, in_ready);
                end else q32.push_back(model(3'(i), 32'd3, 32'd5, 32));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ops_single_cycle: out_valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_div();
        exp_t e;
        int   w;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) issue32(OP_MUL, 32'd3, 32'd5, 1'b1, w);
            else        issue32(OP_DIV, 32'd17, 32'd5, 1'b1, w);
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL multi_busy: op %0d cycle %0d out_valid=%b in_ready=%b required 0 0",
                             k, c, out_valid, in_ready);
                end
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || q32.size() == 0) begin
                errors++;
                $display("FAIL multi_latency: op %0d out_valid=%b required 1", k, out_valid);
            end else begin
                e = q32.pop_front();
                if ({out, zero, carry, div_by_zero} !== {e.res, e.zero, e.carry, e.dbz}) begin
                    errors++;
                    $display("FAIL multi_result: op %0d out=%h z=%b c=%b dbz=%b required %h %b %b %b",
                             k, out, zero, carry, div_by_zero, e.res, e.zero, e.carry, e.dbz);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        int   w;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) issue32(OP_DIV, 32'd9, 32'd0, 1'b1, w);
            else        issue32(OP_ADD, 32'd0, 32'd0, 1'b1, w);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || q32.size() == 0) begin
                errors++;
                $display("FAIL dbz_latency: op %0d out_valid=%b required 1", k, out_valid);
            end else begin
                e = q32.pop_front();
                if ({out, zero, carry, div_by_zero} !== {e.res, e.zero, e.carry, e.dbz}) begin
                    errors++;
                    $display("FAIL dbz_result: op %0d out=%h z=%b c=%b dbz=%b required %h %b %b %b",
                             k, out, zero, carry, div_by_zero, e.res, e.zero, e.carry, e.dbz);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   w;
        out_ready = 1'b0;
        issue32(OP_ADD, 32'd1, 32'd1, 1'b1, w);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out !== 32'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b out=%h in_ready=%b required 1 2 0",
                         c, out_valid, out, in_ready);
            end
        end
        // Consume and accept on the same edge
        in_valid = 1'b1; sel = OP_ADD; a = 32'd4; b = 32'd5; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || q32.size() == 0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b required 1", in_ready);
        end else begin
            e = q32.pop_front();
            if ({out, zero, carry} !== {e.res, e.zero, e.carry}) begin
                errors++;
                $display("FAIL bp_first: out=%h z=%b c=%b required %h %b %b",
                         out, zero, carry, e.res, e.zero, e.carry);
            end
            q32.push_back(model(OP_ADD, 32'd4, 32'd5, 32));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || q32.size() == 0) begin
            errors++;
            $display("FAIL bp_no_bubble: out_valid=%b required 1", out_valid);
        end else begin
            e = q32.pop_front();
            if ({out, zero, carry, div_by_zero} !== {e.res, e.zero, e.carry, e.dbz}) begin
                errors++;
                $display("FAIL bp_second: out=%h z=%b c=%b dbz=%b required %h %b %b %b",
                         out, zero, carry, div_by_zero, e.res, e.zero, e.carry, e.dbz);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        int   w, n;
        bit   seen;
        out_ready = 1'b1;
        issue32(OP_MUL, 32'd7, 32'd6, 1'b0, w);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out, zero, carry, div_by_zero} !== 36'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid=%b out=%h z=%b c=%b dbz=%b rdy=%b required 0s and rdy 1",
                     out_valid, out, zero, carry, div_by_zero, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_mid_abort: out_valid=1 seen, required aborted op to emit nothing");
        end
        @(posedge clk); #1;
        issue32(OP_MUL, 32'd7, 32'd6, 1'b1, w);
        n = 0;
        do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 100);
        checks++;
        if (out_valid !== 1'b1 || n != 33 || q32.size() == 0) begin
            errors++;
            $display("FAIL rst_mid_fresh_latency: out_valid=%b negedges=%0d required 1 33", out_valid, n);
        end else begin
            e = q32.pop_front();
            if ({out, zero, carry} !== {e.res, e.zero, e.carry}) begin
                errors++;
                $display("FAIL rst_mid_fresh: out=%h z=%b c=%b required %h %b %b",
                         out, zero, carry, e.res, e.zero, e.carry);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width8();
        exp_t e;
        int   n, lat;
        logic [7:0] lit_out;
        out_ready8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid8 = 1'b1;
            sel8    = (k == 0) ? OP_MUL : OP_ADD;
            a8      = (k == 0) ? 8'd200 : 8'hFF;
            b8      = (k == 0) ? 8'd2 : 8'h01;
            lat     = (k == 0) ? 9 : 1;
            lit_out = (k == 0) ? 8'h90 : 8'h00;
            @(negedge clk);
            checks++;
            if (in_ready8 !== 1'b1) begin
                errors++;
                $display("FAIL w8_ready: op %0d in_ready8=%b required 1", k, in_ready8);
            end else q8.push_back(model(sel8, {24'd0, a8}, {24'd0, b8}, 8));
            @(posedge clk); #1;
            in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            n = 0;
            do begin @(negedge clk); n++; end while (out_valid8 !== 1'b1 && n < 50);
            checks++;
            if (out_valid8 !== 1'b1 || n != lat) begin
                errors++;
                $display("FAIL w8_latency: op %0d out_valid8=%b negedges=%0d required 1 %0d",
                         k, out_valid8, n, lat);
            end
            checks++;
            if (out8 !== lit_out || carry8 !== 1'b1 || zero8 !== (k == 1)) begin
                errors++;
                $display("FAIL w8_literal: op %0d out8=%h c=%b z=%b required %h 1 %0d",
                         k, out8, carry8, zero8, lit_out, k);
            end
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_scoreboard: queue empty, required an expected entry");
            end else begin
                e = q8.pop_front();
                if ({24'd0, out8} !== e.res || {zero8, carry8, dbz8} !== {e.zero, e.carry, e.dbz}) begin
                    errors++;
                    $display("FAIL w8_result: op %0d out8=%h z=%b c=%b dbz=%b required %h %b %b %b",
                             k, out8, zero8, carry8, dbz8, e.res, e.zero, e.carry, e.dbz);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0; out_ready8 = 1'b1;
        test_reset();
        test_ops_back_to_back();
        test_mul_div();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_mul();
        test_width8();
        checks++;
        if (q32.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d/%0d expected results never produced, required 0/0",
                     q32.size(), q8.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised, handshaked successor to the 32-bit combinational ALU. It keeps the same 3-bit operation encoding: NOT, OR, AND, NEGATION, ADD, SUB, MUL, DIV. Operands are captured on a valid/ready input handshake, and the result is held in an output register until consumed. MUL (shift-add) and DIV (restoring) are multi-cycle iterative units. Status flags are added. The block sits between an operand-issuing controller and a result consumer, and can be instantiated at any WIDTH.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand/opcode offer.
in_ready  output  1  block can accept an operation this cycle.
a  input  WIDTH  operand A (unsigned).
b  input  WIDTH  operand B (unsigned).
sel  input  3  opcode: 000 NOT, 001 OR, 010 AND, 011 NEG, 100 ADD, 101 SUB, 110 MUL, 111 DIV.
out_valid  output  1  result register holds an unconsumed result.
out_ready  input  1  consumer accepts result this cycle.
out  output  WIDTH  result.
zero  output  1  result equals 0.
carry  output  1  ADD carry-out / SUB borrow / MUL overflow; 0 otherwise.
div_by_zero  output  1  DIV issued with b==0.

Behaviour:
- Clocking/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE. out, zero, carry, div_by_zero, out_valid are all 0. Internal accumulators are cleared.
- in_ready = (state==IDLE) && !rst && (!out_valid || out_ready). It is combinational from registered state and out_ready.
- Accept: occurs on a rising edge with in_valid && in_ready. a, b, sel are latched at that edge; later changes on a, b, sel are ignored.
- Output consume: occurs on an edge with out_valid && out_ready, which clears out_valid. If a new result is written at the same edge, the write wins and out_valid stays 1.
- Output fields out, zero, carry, div_by_zero hold their values until the next result write. They are valid only while out_valid=1.
- States: IDLE, MUL, DIV.
  - IDLE + accept of sel 000-101: result written at the accept edge. out_valid=1 is seen in the next cycle (latency 1).
  - IDLE + accept of MUL: state goes to MUL. Iteration counter = 0, 2*WIDTH-bit accumulator = 0.
  - IDLE + accept of DIV with b!=0: state goes to DIV. Remainder = 0, quotient register = a.
  - IDLE + accept of DIV with b==0: no state change. Writes out = all ones, div_by_zero=1, carry=0, latency 1.
  - MUL: one multiplier bit per cycle, LSB first, for WIDTH cycles. On the WIDTH-th iteration edge the result is written and state returns to IDLE. out_valid rises WIDTH edges after the accept edge.
  - DIV: one restoring step per cycle, MSB first, for WIDTH cycles. Same timing as MUL. out = quotient; the remainder is discarded.
- Arithmetic (unsigned, results truncated to WIDTH bits):
  - NOT = ~a
  - NEG = (~a)+1, carry=0
  - ADD: carry = bit WIDTH of a+b
  - SUB = a-b: carry = 1 iff a<b
  - MUL: out = low WIDTH bits of the product; carry = 1 iff the high WIDTH bits are nonzero
  - Logic ops: carry=0.
- zero is computed from the written result.
- in_ready is 0 throughout MUL/DIV. It is also 0 while out_valid=1 and out_ready=0 (backpressure). No operation is ever dropped or overwritten.
- Reset mid-operation (any state): the operation is aborted with no result written. All outputs follow reset values the cycle after the rst edge. in_ready returns to 1 in the first cycle with rst=0.
- Corner cases:
  - NEG of 0 gives 0, zero=1.
  - NEG of 1<<(WIDTH-1) returns itself.
  - a=0 MUL/DIV still take the full WIDTH cycles; latency is data-independent.

Test Plan:
1. WIDTH=32, a=3, b=5, each of sel 000-101 issued back-to-back with out_ready=1 -> results (one per cycle):
   - NOT: 0xFFFFFFFC
   - OR: 0x7
   - AND: 0x1
   - NEG: 0xFFFFFFFD
   - ADD: 0x8, carry=0
   - SUB: 0xFFFFFFFE, carry=1
   - Each result valid exactly 1 cycle after its accept.
2. WIDTH=32, MUL 3*5 then DIV 17/5 -> out=15 with out_valid 32 edges after accept and in_ready=0 meanwhile; then out=3, zero=0.
3. DIV a=9, b=0 -> out=0xFFFFFFFF, div_by_zero=1, latency 1. Next ADD 0+0 -> out=0, zero=1, div_by_zero=0.
4. Backpressure: ADD 1+1 with out_ready=0 for 5 cycles -> out=2 held, out_valid=1, in_ready=0 throughout. Raise out_ready with in_valid high -> simultaneous consume+accept, next result follows without bubble.
5. rst pulsed 10 cycles into a MUL -> no result emitted, all outputs 0, in_ready=1 first cycle after rst low. Fresh MUL 7*6 -> 42.
6. WIDTH=8 instance:
   - MUL 200*2 -> out=0x90, carry=1, valid 8 edges after accept.
   - ADD 0xFF+0x01 -> out=0, carry=1, zero=1.
